// File: rtl/m_input_port.sv
// Handshaked input port: synchronizes a device strobe, captures bytes into a
// 2-entry FIFO with a four-phase acknowledge, and serves CPU data/status reads.
//
// state | meaning
// IDLE  | oDevAck low; capture on synchronized strobe when FIFO not full
// ACK   | oDevAck high; waiting for synchronized strobe to drop
module m_input_port #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [WIDTH-1:0] iDevData,
  input  logic             iDevStrobe,
  output logic             oDevAck,
  input  logic             iRead,
  input  logic             iStatusSel,
  output logic [WIDTH-1:0] oData,
  output logic             oReady,
  output logic             oUnderflow
);

  typedef enum logic {IDLE, ACK} tState;

  tState                  state, nextState;
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   sStrobe;
  logic [WIDTH-1:0]       fifoMem [2];
  logic                   headPtr, tailPtr;
  logic [1:0]             count;
  logic                   full;
  logic                   captureEn, popEn, dataRead, statusRead;
  logic [WIDTH-1:0]       statusByte;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) syncQ <= '0;
    else         syncQ <= {syncQ[SYNC_STAGES-2:0], iDevStrobe};
  end

  assign sStrobe    = syncQ[SYNC_STAGES-1];
  assign full       = (count == 2'd2);
  assign oReady     = (count != 2'd0);
  assign oDevAck    = (state == ACK);
  assign dataRead   = iRead & ~iStatusSel;
  assign statusRead = iRead & iStatusSel;
  assign popEn      = dataRead & oReady;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= nextState;
  end

  // Capture is gated by the pre-edge count, so a pop on a full FIFO frees a slot
  // that is only filled on the following edge.
  always_comb begin
    nextState = state;
    captureEn = 1'b0;
    case (state)
      IDLE: begin
        if (sStrobe && !full) begin
          captureEn = 1'b1;
          nextState = ACK;
        end
      end
      ACK: begin
        if (!sStrobe) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fifoMem[0] <= '0;
      fifoMem[1] <= '0;
      headPtr    <= 1'b0;
      tailPtr    <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (captureEn) begin
        fifoMem[tailPtr] <= iDevData;
        tailPtr          <= ~tailPtr;
      end
      if (popEn) headPtr <= ~headPtr;
      case ({captureEn, popEn})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                  oUnderflow <= 1'b0;
    else if (dataRead && !oReady) oUnderflow <= 1'b1;
    else if (statusRead)          oUnderflow <= 1'b0;
  end

  always_comb begin
    statusByte          = '0;
    statusByte[WIDTH-1] = oReady;
    statusByte[WIDTH-2] = full;
    statusByte[WIDTH-3] = oDevAck;
    statusByte[1:0]     = count;
  end

  always_comb begin
    oData = '0;
    if (iStatusSel)  oData = statusByte;
    else if (oReady) oData = fifoMem[headPtr];
  end

endmodule

// File: tb/tb_m_input_port.sv
// Bench for m_input_port: directed handshake/FIFO scenarios plus a randomized
// device/CPU phase, all checked against a queue-based behavioural model.
module tb_m_input_port;

  localparam int SYNC_STAGES = 2;

  logic       iClk, iRst_n;
  logic [7:0] iDevData;
  logic       iDevStrobe, oDevAck, iRead, iStatusSel;
  logic [7:0] oData;
  logic       oReady, oUnderflow;

  int vecCount = 0;
  int errCount = 0;

  // behavioural model
  logic [7:0] q [$];
  logic       strobeHist [$];
  logic       mAck, mUnder;

  m_input_port #(.WIDTH(8), .SYNC_STAGES(SYNC_STAGES)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iDevData(iDevData), .iDevStrobe(iDevStrobe),
    .oDevAck(oDevAck), .iRead(iRead), .iStatusSel(iStatusSel), .oData(oData),
    .oReady(oReady), .oUnderflow(oUnderflow)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] expData();
    int n = q.size();
    if (iStatusSel) return {n != 0, n == 2, mAck, 3'b000, n[1:0]};
    if (n != 0) return q[0];
    return 8'h00;
  endfunction

  task automatic modelReset();
    q.delete();
    strobeHist.delete();
    repeat (SYNC_STAGES) strobeHist.push_back(1'b0);
    mAck   = 1'b0;
    mUnder = 1'b0;
  endtask

  task automatic checkModel();
    checkVal("data", oData, expData());
    checkVal("ready", oReady, q.size() != 0);
    checkVal("ack", oDevAck, mAck);
    checkVal("underflow", oUnderflow, mUnder);
  endtask

  task automatic drive(input logic stb, input logic [7:0] d, input logic rd, input logic sel);
    @(negedge iClk);
    iDevStrobe = stb;
    iDevData   = d;
    iRead      = rd;
    iStatusSel = sel;
    #1;
    checkModel();
  endtask

  task automatic tick();
    logic s;
    int   preSize;
    logic preAck;
    @(posedge iClk);
    s = strobeHist.pop_front();
    strobeHist.push_back(iDevStrobe);
    preSize = q.size();
    preAck  = mAck;
    if (iRead && !iStatusSel) begin
      if (preSize > 0) void'(q.pop_front());
      else mUnder = 1'b1;
    end else if (iRead && iStatusSel) begin
      mUnder = 1'b0;
    end
    if (!preAck && s && preSize < 2) begin
      q.push_back(iDevData);
      mAck = 1'b1;
    end else if (preAck && !s) begin
      mAck = 1'b0;
    end
  endtask

  task automatic raiseUntilAck(input logic [7:0] b, output int edges);
    logic got;
    edges = 0;
    forever begin
      drive(1'b1, b, 1'b0, 1'b0);
      got = oDevAck;
      tick();
      if (got || edges > 10) break;
      edges++;
    end
    checkVal("ackRise", got, 1'b1);
  endtask

  task automatic dropUntilIdle(input logic [7:0] b);
    logic got;
    int   edges = 0;
    forever begin
      drive(1'b0, b, 1'b0, 1'b0);
      got = oDevAck;
      tick();
      if (!got || edges > 10) break;
      edges++;
    end
    checkVal("ackFall", got, 1'b0);
    checkVal("ackFallEdges", edges <= SYNC_STAGES + 1, 1'b1);
  endtask

  task automatic offer(input logic [7:0] b);
    int edges;
    raiseUntilAck(b, edges);
    checkVal("ackRiseEdges", edges <= SYNC_STAGES + 1, 1'b1);
    dropUntilIdle(b);
  endtask

  initial begin
    int   edges;
    int   devPhase;
    logic stb, rd, sel, capNext, got;
    logic [7:0] d;

    iRst_n = 1'b0; iDevData = 8'h00; iDevStrobe = 1'b0; iRead = 1'b0; iStatusSel = 1'b0;
    modelReset();
    #2;
    checkModel();
    #14;
    iRst_n = 1'b1;

    // underflow: empty data read, then status read clears the flag
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("uflowData", oData, 8'h00);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    checkVal("uflowFlag", oUnderflow, 1'b1);
    checkVal("statusBit7", oData[7], 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checkVal("uflowClr", oUnderflow, 1'b0);
    tick();

    // single byte
    offer(8'hA5);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("readA5", oData, 8'hA5);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    checkVal("readyClr", oReady, 1'b0);
    tick();

    // full stall and pop-then-capture
    offer(8'h11);
    offer(8'h22);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'h33, 1'b0, 1'b1);
      checkVal("stallAck", oDevAck, 1'b0);
      checkVal("stallStatus", oData, 8'hC2);
      tick();
    end
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    checkVal("pop11", oData, 8'h11);
    tick();
    edges = 0;
    forever begin
      drive(1'b1, 8'h33, 1'b0, 1'b0);
      got = oDevAck;
      tick();
      if (got || edges > 10) break;
      edges++;
    end
    checkVal("capAfterPop", got && edges >= 1 && edges <= 2, 1'b1);
    dropUntilIdle(8'h33);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("pop22", oData, 8'h22);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("pop33", oData, 8'h33);
    tick();

    // count=1 with a read on the capture edge
    offer(8'h44);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      capNext = !mAck && strobeHist[0] && q.size() < 2;
      drive(1'b1, 8'h55, capNext, 1'b0);
      if (capNext) checkVal("simulPop", oData, 8'h44);
      tick();
      got = capNext;
    end
    checkVal("simulSeen", got, 1'b1);
    drive(1'b1, 8'h55, 1'b0, 1'b1);
    checkVal("simulCount", oData[1:0], 2'd1);
    tick();
    dropUntilIdle(8'h55);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checkVal("pop55", oData, 8'h55);
    tick();

    // wrap-around
    for (int i = 1; i <= 6; i++) begin
      offer(i[7:0]);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checkVal("wrap", oData, i[7:0]);
      tick();
    end

    // async reset mid-ACK with count=1 and underflow set
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    raiseUntilAck(8'h66, edges);
    #2;
    iRst_n = 1'b0;
    #1;
    checkVal("rstAck", oDevAck, 1'b0);
    checkVal("rstReady", oReady, 1'b0);
    checkVal("rstUflow", oUnderflow, 1'b0);
    checkVal("rstData", oData, 8'h00);
    iStatusSel = 1'b1;
    #0.5;
    checkVal("rstStatus", oData, 8'h00);
    iDevStrobe = 1'b0;
    iStatusSel = 1'b0;
    #0.5;
    iRst_n = 1'b1;
    modelReset();

    // randomized device and CPU traffic
    devPhase = 0;
    stb = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 1500; i++) begin
      case (devPhase)
        0: if ($urandom_range(2) == 0) begin stb = 1'b1; d = 8'($urandom); devPhase = 1; end
        1: if (mAck && $urandom_range(1) == 0) begin stb = 1'b0; devPhase = 2; end
        default: if (!mAck) devPhase = 0;
      endcase
      rd  = ($urandom_range(3) == 0);
      sel = ($urandom_range(3) == 0);
      drive(stb, d, rd, sel);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
